// File: rtl/simple_cpu_pkg.sv
// Shared constants, opcode/condition encodings and decode helpers for simple_cpu.
package simple_cpu_pkg;

    localparam int DATA_W    = 8;
    localparam int MEM_WORDS = 32;
    localparam int NREGS     = 4;
    localparam int ADDR_W    = 5;
    localparam int REG_W     = 2;
    localparam int OFS_W     = 4;

    // Loads and stores only reach the upper half of memory.
    localparam logic [ADDR_W-1:0] DATA_BASE = 5'h10;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_SUB   = 2'b10,
        OP_BR    = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        BR_ALWAYS = 2'b00,
        BR_Z      = 2'b01,
        BR_NZ     = 2'b10,
        BR_NEVER  = 2'b11
    } brcond_e;

    // Map a 4-bit instruction offset into the data window.
    function automatic logic [ADDR_W-1:0] data_addr(input logic [OFS_W-1:0] ofs);
        return DATA_BASE | {1'b0, ofs};
    endfunction

    // Branch decision from the condition field and the current zero flag.
    function automatic logic br_taken(input brcond_e c, input logic z);
        logic t;
        case (c)
            BR_ALWAYS: t = 1'b1;
            BR_Z:      t = z;
            BR_NZ:     t = ~z;
            default:   t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/simple_cpu_if.sv
// Operand/result bundle between the CPU core and its subtract unit.
interface simple_cpu_if;
    import simple_cpu_pkg::*;

    logic [DATA_W-1:0] a;     // minuend
    logic [DATA_W-1:0] b;     // subtrahend
    logic [DATA_W-1:0] diff;  // a - b, mod 256
    logic              zero;  // diff == 0

    modport master (output a, b, input diff, zero);
    modport slave  (input a, b, output diff, zero);
endinterface

// File: rtl/simple_cpu_alu.sv
// 8-bit wrapping subtractor with zero detect.
module simple_cpu_alu
    import simple_cpu_pkg::*;
(
    simple_cpu_if.slave bus
);

    logic [DATA_W-1:0] diff;

    // Subtract modulo 2^DATA_W; zero flag follows the truncated result.
    always_comb begin
        diff     = bus.a - bus.b;
        bus.diff = diff;
        bus.zero = (diff == '0);
    end

endmodule

// File: rtl/simple_cpu.sv
// Single-cycle 8-bit CPU: 4-entry register file, unified 32-byte code/data memory.
module simple_cpu
    import simple_cpu_pkg::*;
(
    input logic clk,
    input logic reset
);

    logic [DATA_W-1:0] memory  [0:MEM_WORDS-1];
    logic [DATA_W-1:0] regfile [0:NREGS-1];
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] instr;
    logic              Z;

    opcode_e           op;
    brcond_e           cond;
    logic [REG_W-1:0]  f_rd;
    logic [REG_W-1:0]  f_rs;
    logic [REG_W-1:0]  f_rt;
    logic [OFS_W-1:0]  f_ofs;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] pc_d;

    simple_cpu_if alu_bus ();

    // Asynchronous fetch: the current instruction is whatever memory holds at PC this cycle.
    assign instr    = memory[PC];
    assign op       = opcode_e'(instr[7:6]);
    assign cond     = brcond_e'(instr[5:4]);
    assign f_rd     = instr[5:4];
    assign f_rs     = instr[3:2];
    assign f_rt     = instr[1:0];
    assign f_ofs    = instr[3:0];
    assign mem_addr = data_addr(f_ofs);

    // SUB computes regfile[rt] - regfile[rs]; operands are read before any write.
    assign alu_bus.a = regfile[f_rt];
    assign alu_bus.b = regfile[f_rs];

    simple_cpu_alu u_alu (
        .bus (alu_bus.slave)
    );

    // Next PC: sequential with 5-bit wrap unless a branch is taken into the low half.
    always_comb begin
        pc_d = PC + 1'b1;
        if (op == OP_BR && br_taken(cond, Z)) begin
            pc_d = {1'b0, f_ofs};
        end
    end

    // Architectural state commit: PC, register file and zero flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= '0;
            Z  <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            PC <= pc_d;
            case (op)
                OP_LOAD: regfile[f_rd] <= memory[mem_addr];
                OP_SUB: begin
                    regfile[f_rd] <= alu_bus.diff;
                    Z             <= alu_bus.zero;
                end
                default: ;
            endcase
        end
    end

    // Memory is never cleared; stores are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && op == OP_STORE) begin
            memory[mem_addr] <= regfile[f_rd];
        end
    end

endmodule

// File: tb/tb_simple_cpu.sv
// Directed bench for simple_cpu: countdown program, resets, SUB wrap, branches, PC wrap.
module tb_simple_cpu;
    import simple_cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    simple_cpu dut (
        .clk   (clk),
        .reset (reset)
    );

    simple_cpu_if alu_bus ();

    simple_cpu_alu u_ref_alu (
        .bus (alu_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) dut.memory[i] = 8'h00;
    endtask

    task automatic load_countdown();
        logic [7:0] prog [0:11];
        prog = '{8'h11, 8'h22, 8'h99, 8'h53, 8'h13, 8'hDB,
                 8'hDB, 8'h99, 8'h53, 8'hC4, 8'hC4, 8'hCB};
        clear_mem();
        for (int i = 0; i < 12; i++) dut.memory[i] = prog[i];
        dut.memory[17] = 8'd5;
        dut.memory[18] = 8'd1;
    endtask

    initial begin
        reset = 1'b1;
        load_countdown();
        tick(1);

        // Reset state from power-up
        chk("rst_pc", {3'b0, dut.PC}, 8'd0);
        chk("rst_r0", dut.regfile[0], 8'd0);
        chk("rst_r1", dut.regfile[1], 8'd0);
        chk("rst_r3", dut.regfile[3], 8'd0);
        chk("rst_z",  {7'b0, dut.Z}, 8'd0);

        // Countdown: first store after 4 instructions
        reset = 1'b0;
        tick(4);
        chk("cd4_mem19", dut.memory[19], 8'd4);
        chk("cd4_r1",    dut.regfile[1], 8'd4);
        chk("cd4_pc",    {3'b0, dut.PC}, 8'd4);

        // One loop iteration later (cycle 10)
        tick(6);
        chk("cd10_mem19", dut.memory[19], 8'd3);
        chk("cd10_pc",    {3'b0, dut.PC}, 8'd4);

        // Mid-run reset: state cleared, memory keeps stored value
        reset = 1'b1;
        tick(1);
        chk("mid_pc",    {3'b0, dut.PC}, 8'd0);
        chk("mid_r1",    dut.regfile[1], 8'd0);
        chk("mid_r2",    dut.regfile[2], 8'd0);
        chk("mid_mem19", dut.memory[19], 8'd3);
        reset = 1'b0;

        // Rerun to completion, then confirm halt is stable
        tick(40);
        chk("fin_pc",    {3'b0, dut.PC}, 8'd11);
        chk("fin_r1",    dut.regfile[1], 8'd0);
        chk("fin_r2",    dut.regfile[2], 8'd1);
        chk("fin_mem19", dut.memory[19], 8'd0);
        chk("fin_z",     {7'b0, dut.Z}, 8'd1);
        tick(3);
        chk("halt_pc",    {3'b0, dut.PC}, 8'd11);
        chk("halt_mem19", dut.memory[19], 8'd0);

        // Three-cycle reset over non-zero state
        reset = 1'b1;
        tick(3);
        chk("rst3_pc",    {3'b0, dut.PC}, 8'd0);
        chk("rst3_r2",    dut.regfile[2], 8'd0);
        chk("rst3_z",     {7'b0, dut.Z}, 8'd0);
        chk("rst3_mem0",  dut.memory[0], 8'h11);
        chk("rst3_mem11", dut.memory[11], 8'hCB);
        chk("rst3_mem17", dut.memory[17], 8'd5);

        // SUB wrap and zero: R0 = R1 - R2
        clear_mem();
        dut.memory[0]  = 8'h10;  // LOAD R1,[0x10]
        dut.memory[1]  = 8'h21;  // LOAD R2,[0x11]
        dut.memory[2]  = 8'h89;  // SUB R0 = R1 - R2
        dut.memory[3]  = 8'h12;  // LOAD R1,[0x12]
        dut.memory[4]  = 8'h22;  // LOAD R2,[0x12]
        dut.memory[5]  = 8'h89;
        dut.memory[6]  = 8'h10;  // LOAD R1,[0x10]
        dut.memory[7]  = 8'h89;
        dut.memory[8]  = 8'hC8;  // halt
        dut.memory[16] = 8'd1;
        dut.memory[17] = 8'd3;
        dut.memory[18] = 8'd7;
        tick(1);
        reset = 1'b0;
        tick(3);
        chk("sub_wrap_r0", dut.regfile[0], 8'hFE);
        chk("sub_wrap_z",  {7'b0, dut.Z}, 8'd0);
        chk("sub_wrap_r1", dut.regfile[1], 8'd1);
        tick(3);
        chk("sub_zero_r0", dut.regfile[0], 8'h00);
        chk("sub_zero_z",  {7'b0, dut.Z}, 8'd1);
        tick(2);
        chk("sub_neg_r0", dut.regfile[0], 8'hFA);
        chk("sub_neg_z",  {7'b0, dut.Z}, 8'd0);

        // Branch conditions with Z=0
        reset = 1'b1;
        clear_mem();
        dut.memory[0] = 8'hD7;  // BR Z  -> 7 (not taken)
        dut.memory[1] = 8'hE7;  // BR NZ -> 7 (taken)
        dut.memory[7] = 8'hF5;  // never (NOP)
        dut.memory[8] = 8'hC3;  // always -> 3
        dut.memory[3] = 8'hC3;  // self-jump
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("br_z_nt",   {3'b0, dut.PC}, 8'd1);
        tick(1);
        chk("br_nz_t",   {3'b0, dut.PC}, 8'd7);
        tick(1);
        chk("br_never",  {3'b0, dut.PC}, 8'd8);
        tick(1);
        chk("br_always", {3'b0, dut.PC}, 8'd3);
        tick(1);
        chk("br_self",   {3'b0, dut.PC}, 8'd3);

        // PC wrap from 31 to 0 through NOPs
        reset = 1'b1;
        clear_mem();
        dut.memory[0] = 8'hCF;  // always -> 15
        for (int i = 15; i < 32; i++) dut.memory[i] = 8'hF0;
        tick(1);
        reset = 1'b0;
        tick(1);
        chk("wrap_pc15", {3'b0, dut.PC}, 8'd15);
        tick(16);
        chk("wrap_pc31", {3'b0, dut.PC}, 8'd31);
        tick(1);
        chk("wrap_pc0",  {3'b0, dut.PC}, 8'd0);

        // Standalone subtract unit
        alu_bus.a = 8'h00;
        alu_bus.b = 8'h01;
        #1;
        chk("alu_diff_ff", alu_bus.diff, 8'hFF);
        chk("alu_zero_0",  {7'b0, alu_bus.zero}, 8'd0);
        alu_bus.a = 8'h80;
        alu_bus.b = 8'h80;
        #1;
        chk("alu_diff_00", alu_bus.diff, 8'h00);
        chk("alu_zero_1",  {7'b0, alu_bus.zero}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
